// File: rtl/pipe_share_pkg.sv
// pipe_share_pkg
//   Shared definitions for the pipe_share_arb slice.
//   - state_e : arbiter operating mode (RUN, DRAIN, DRAINED)
//   - STATS_W : width of each per-requester grant statistics counter
//               (only used when PIPE_SHARE_ARB_STATS_EN is defined)
package pipe_share_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/data_pipeline.sv
// data_pipeline
//   Fixed-latency register pipeline: data_o is data_i delayed by PIPE_DEPTH
//   clocks. No handshake; every stage shifts on every clock.
//   Parameters: DATA_W (width), PIPE_DEPTH (stages, >=1),
//               RST_EN (1 = stages clear on reset), RST_VAL (clear value).
//   Ports:
//     clk    in  clock
//     rst    in  synchronous active-high reset (ignored when RST_EN=0)
//     data_i in  DATA_W stage-0 input
//     data_o out DATA_W output of the last stage
module data_pipeline #(
  parameter int                DATA_W     = 32,
  parameter int                PIPE_DEPTH = 3,
  parameter bit                RST_EN     = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] stage_q [PIPE_DEPTH];

  // Shift register: stage 0 captures the input, every later stage takes the
  // value of the one before it. With RST_EN set, reset clears every stage so
  // nothing that was in flight survives.
  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[PIPE_DEPTH-1];

endmodule

// File: rtl/pipe_share_arb.sv
// pipe_share_arb
//   Round-robin arbiter that shares one fixed-latency external pipeline among
//   NUM_REQ requesters. One request is accepted per cycle, registered onto
//   pipe_*_o, and the requester id rides an internal tag pipeline so the
//   pipeline result can be steered back with a one-hot strobe. Each requester
//   may have at most MAX_OUT items outstanding. A flush request stops new
//   grants and reports idle once everything has returned.
//   Optional feature macro: PIPE_SHARE_ARB_STATS_EN adds grant_cnt_o.
//   Ports:
//     clk          in  clock
//     rst          in  synchronous active-low reset
//     req_valid_i  in  NUM_REQ request valids
//     req_data_i   in  NUM_REQ*DATA_W payloads, requester k at [k*DATA_W +: DATA_W]
//     req_ready_o  out NUM_REQ one-hot grant (combinational)
//     pipe_valid_o out registered issue valid
//     pipe_data_o  out DATA_W registered issue payload (holds when idle)
//     pipe_data_i  in  DATA_W external pipeline result
//     rsp_valid_o  out NUM_REQ one-hot result strobe
//     rsp_data_o   out DATA_W result payload (pass-through of pipe_data_i)
//     flush_i      in  drain request
//     idle_o       out high when fully drained
//     grant_cnt_o  out NUM_REQ*16 saturating grant counters (stats build only)
module pipe_share_arb
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int MAX_OUT    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      pipe_valid_o,
  output logic [DATA_W-1:0]         pipe_data_o,
  input  logic [DATA_W-1:0]         pipe_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  input  logic                      flush_i,
  output logic                      idle_o
`ifdef PIPE_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt_o
`endif
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = 1 + ID_W;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  out_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]  out_cnt_d [NUM_REQ];
  logic              cnt_zero_d;
  logic              issue_valid_q;
  logic [ID_W-1:0]   issue_id_q;
  logic [NUM_REQ-1:0] eligible;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [TAG_W-1:0]  tag_in;
  logic [TAG_W-1:0]  tag_out;
  logic              tag_valid;
  logic [ID_W-1:0]   tag_id;
  logic              drain_done;

  // A requester may compete only while it still has room for another
  // outstanding item.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = req_valid_i[k] && (out_cnt_q[k] < CNT_W'(MAX_OUT));
    end
  end

  // Round-robin search starting at rr_ptr with wrap-around. Grants happen
  // only in RUN and never while reset is asserted, so nothing is accepted
  // that the reset would immediately throw away.
  always_comb begin : arb_comb
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (rst && (state_q == RUN)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (!grant_any && eligible[idx]) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
  end

  // One-hot accept back to the winning requester.
  always_comb begin
    req_ready_o = '0;
    if (grant_any) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  // Issue register: the grant's payload appears on the pipeline port one
  // cycle later. pipe_data_o deliberately holds its value on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      pipe_data_o   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      issue_valid_q <= grant_any;
      if (grant_any) begin
        issue_id_q  <= grant_id;
        pipe_data_o <= req_data_i[grant_id*DATA_W +: DATA_W];
        rr_ptr_q    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign pipe_valid_o = issue_valid_q;

  // The tag follows the registered issue so it lines up with the external
  // pipeline result PIPE_DEPTH cycles later. Its stages clear on reset,
  // which is what discards results of items in flight at reset.
  assign tag_in = {issue_valid_q, issue_id_q};

  data_pipeline #(
    .DATA_W     (TAG_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .RST_EN     (1'b1),
    .RST_VAL    ('0)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (~rst),
    .data_i (tag_in),
    .data_o (tag_out)
  );

  assign tag_valid  = tag_out[TAG_W-1];
  assign tag_id     = tag_out[ID_W-1:0];
  assign rsp_data_o = pipe_data_i;

  // Steer the returning result to its owner. Masked during reset because the
  // tag stages only clear at the reset edge.
  always_comb begin
    rsp_valid_o = '0;
    if (rst && tag_valid) begin
      rsp_valid_o[tag_id] = 1'b1;
    end
  end

  // Next outstanding counts: a grant and a response for the same requester
  // in one cycle cancel out. The zero guard keeps a stray response from
  // wrapping the counter.
  always_comb begin
    cnt_zero_d = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      out_cnt_d[k] = out_cnt_q[k];
      if (req_ready_o[k] && !rsp_valid_o[k]) begin
        out_cnt_d[k] = out_cnt_q[k] + 1'b1;
      end else if (!req_ready_o[k] && rsp_valid_o[k] && (out_cnt_q[k] != '0)) begin
        out_cnt_d[k] = out_cnt_q[k] - 1'b1;
      end
      if (out_cnt_d[k] != '0) begin
        cnt_zero_d = 1'b0;
      end
    end
  end

  // Outstanding-item counters per requester.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rst) begin
        out_cnt_q[k] <= '0;
      end else begin
        out_cnt_q[k] <= out_cnt_d[k];
      end
    end
  end

  // Drain completes when the last outstanding item returns this cycle, so
  // idle_o rises the cycle right after the final response strobe. Every
  // issued item is still counted, so the issue register check only guards
  // against a mismatch between the two.
  assign drain_done = cnt_zero_d && !issue_valid_q;

  // Mode FSM. idle_o is registered alongside the state so it is a clean
  // flop output equal to "state is DRAINED".
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      idle_o  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          idle_o <= 1'b0;
          if (flush_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= flush_i ? DRAINED : RUN;
            idle_o  <= flush_i;
          end else begin
            idle_o  <= 1'b0;
          end
        end
        DRAINED: begin
          if (!flush_i) begin
            state_q <= RUN;
            idle_o  <= 1'b0;
          end else begin
            idle_o  <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          idle_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SHARE_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt_q [NUM_REQ];

  // Per-requester grant counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rst) begin
        grant_cnt_q[k] <= '0;
      end else if (req_ready_o[k] && (grant_cnt_q[k] != '1)) begin
        grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
      end
    end
  end

  // Pack the counters onto the flat output bus.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_cnt_o[k*STATS_W +: STATS_W] = grant_cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_share_arb.sv
// tb_pipe_share_arb
//   Self-checking bench for pipe_share_arb (NUM_REQ=4, PIPE_DEPTH=3,
//   MAX_OUT=2). The shared external pipeline is a data_pipeline of depth 3.
//   A behavioural model (outstanding counts, rotating pointer, and a
//   cycle-indexed schedule of returning items) predicts every output each
//   cycle; directed phases add literal expectations that pin the model.
//   Build with PIPE_SHARE_ARB_STATS_EN to also check grant_cnt_o.
module tb_pipe_share_arb;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int PIPE_DEPTH = 3;
  localparam int MAX_OUT    = 2;
  localparam int LAT        = PIPE_DEPTH + 1;
  localparam int SCH_N      = 64;
  localparam int M_RUN      = 0;
  localparam int M_DRAIN    = 1;
  localparam int M_IDLE     = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      pipe_valid_o;
  logic [DATA_W-1:0]         pipe_data_o;
  logic [DATA_W-1:0]         pipe_data_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      flush_i;
  logic                      idle_o;
`ifdef PIPE_SHARE_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_share_arb #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .pipe_valid_o (pipe_valid_o),
    .pipe_data_o  (pipe_data_o),
    .pipe_data_i  (pipe_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .flush_i      (flush_i),
    .idle_o       (idle_o)
`ifdef PIPE_SHARE_ARB_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt_o)
`endif
  );

  data_pipeline #(
    .DATA_W     (DATA_W),
    .PIPE_DEPTH (PIPE_DEPTH),
    .RST_EN     (1'b0),
    .RST_VAL    ('0)
  ) ext_pipe (
    .clk    (clk),
    .rst    (1'b0),
    .data_i (pipe_data_o),
    .data_o (pipe_data_i)
  );

  // Model state
  int          m_cnt [NUM_REQ];
  int          m_stat [NUM_REQ];
  int          m_ptr;
  int          m_mode;
  bit          m_issue_valid;
  logic [31:0] m_pipe_data;
  bit          m_known;
  bit          sch_valid [SCH_N];
  int          sch_id [SCH_N];
  logic [31:0] sch_data [SCH_N];
  int          cyc;

  int n_checks;
  int n_pass;

  // Snapshots of DUT outputs taken at the compare point of the last cycle
  logic [3:0]  snap_ready;
  logic [3:0]  snap_rsp;
  logic        snap_idle;
  logic        snap_pvalid;
  logic [31:0] snap_pdata;
  logic [15:0] snap_gcnt1;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic fl);
    rst         = r;
    req_valid_i = v;
    flush_i     = fl;
    req_data_i  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic modelReset();
    for (int k = 0; k < NUM_REQ; k++) begin
      m_cnt[k]  = 0;
      m_stat[k] = 0;
    end
    for (int s = 0; s < SCH_N; s++) sch_valid[s] = 1'b0;
    m_ptr         = 0;
    m_mode        = M_RUN;
    m_issue_valid = 1'b0;
    m_pipe_data   = '0;
    m_known       = 1'b1;
  endtask

  // Compare all outputs against the model, then advance the model by one clock
  task automatic checkOutput();
    int          g;
    int          k;
    int          slot;
    bit          empty;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rsp;
    logic [31:0] gdata;
    snap_ready  = req_ready_o;
    snap_rsp    = rsp_valid_o;
    snap_idle   = idle_o;
    snap_pvalid = pipe_valid_o;
    snap_pdata  = pipe_data_o;
`ifdef PIPE_SHARE_ARB_STATS_EN
    snap_gcnt1  = grant_cnt_o[16 +: 16];
`else
    snap_gcnt1  = '0;
`endif
    g         = -1;
    slot      = cyc % SCH_N;
    exp_ready = '0;
    exp_rsp   = '0;
    gdata     = '0;
    if (rst) begin
      if (m_mode == M_RUN) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          k = (m_ptr + i) % NUM_REQ;
          if (g < 0 && req_valid_i[k] && m_cnt[k] < MAX_OUT) g = k;
        end
      end
      if (g >= 0) begin
        exp_ready = 4'b0001 << g;
        gdata     = req_data_i[g*DATA_W +: DATA_W];
      end
      if (sch_valid[slot]) exp_rsp = 4'b0001 << sch_id[slot];
    end
    if (m_known) begin
      checkVal("req_ready", req_ready_o, exp_ready);
      checkVal("pipe_valid", pipe_valid_o, m_issue_valid);
      checkVal("pipe_data", pipe_data_o, m_pipe_data);
      checkVal("rsp_valid", rsp_valid_o, exp_rsp);
      if (exp_rsp != 0) checkVal("rsp_data", rsp_data_o, sch_data[slot]);
      checkVal("idle", idle_o, (m_mode == M_IDLE) ? 1'b1 : 1'b0);
`ifdef PIPE_SHARE_ARB_STATS_EN
      for (int j = 0; j < NUM_REQ; j++)
        checkVal("grant_cnt", grant_cnt_o[j*16 +: 16], m_stat[j]);
`endif
    end
    if (!rst) begin
      modelReset();
    end else if (m_known) begin
      if (sch_valid[slot]) begin
        m_cnt[sch_id[slot]]--;
        sch_valid[slot] = 1'b0;
      end
      if (g >= 0) begin
        m_cnt[g]++;
        if (m_stat[g] < 65535) m_stat[g]++;
        m_ptr = (g + 1) % NUM_REQ;
        sch_valid[(cyc + LAT) % SCH_N] = 1'b1;
        sch_id[(cyc + LAT) % SCH_N]    = g;
        sch_data[(cyc + LAT) % SCH_N]  = gdata;
        m_issue_valid = 1'b1;
        m_pipe_data   = gdata;
      end else begin
        m_issue_valid = 1'b0;
      end
      empty = 1'b1;
      for (int j = 0; j < NUM_REQ; j++) if (m_cnt[j] != 0) empty = 1'b0;
      case (m_mode)
        M_RUN:   if (flush_i) m_mode = M_DRAIN;
        M_DRAIN: if (empty) m_mode = flush_i ? M_IDLE : M_RUN;
        default: if (!flush_i) m_mode = M_RUN;
      endcase
    end
    cyc++;
  endtask

  task automatic runCycle(input logic r, input logic [3:0] v, input logic fl);
    applyStimulus(r, v, fl);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] solo_pat;
    logic       rfl;
    logic       rrst;
    logic [3:0] rv;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    m_known  = 1'b0;
    for (int s = 0; s < SCH_N; s++) sch_valid[s] = 1'b0;
    rst = 1'b0; req_valid_i = '0; req_data_i = '0; flush_i = 1'b0;
    @(posedge clk);
    #1;
    runCycle(1'b0, 4'h0, 1'b0);
    runCycle(1'b0, 4'h0, 1'b0);

    // Reset state
    runCycle(1'b1, 4'h0, 1'b0);
    checkVal("reset_pipe_valid", snap_pvalid, 1'b0);
    checkVal("reset_pipe_data", snap_pdata, 32'h0);
    checkVal("reset_idle", snap_idle, 1'b0);

    // All four requesters valid: strict rotation, responses LAT cycles later
    for (int i = 0; i < 12; i++) begin
      runCycle(1'b1, 4'hF, 1'b0);
      checkVal("rr_order", snap_ready, 4'b0001 << (i % 4));
      if (i >= LAT) checkVal("rr_rsp", snap_rsp, 4'b0001 << ((i - LAT) % 4));
    end
    runCycle(1'b0, 4'h0, 1'b0);

    // Only requester 2: two grants, blocked at MAX_OUT, then one per response
    solo_pat = 10'b0001100011;
    for (int i = 0; i < 10; i++) begin
      runCycle(1'b1, 4'b0100, 1'b0);
      checkVal("solo_ready", snap_ready, solo_pat[i] ? 4'b0100 : 4'b0000);
    end
    runCycle(1'b0, 4'h0, 1'b0);

    // Flush with three items in flight
    for (int i = 0; i < 3; i++) runCycle(1'b1, 4'hF, 1'b0);
    runCycle(1'b1, 4'h0, 1'b1);
    for (int c = 4; c < 9; c++) begin
      runCycle(1'b1, 4'hF, 1'b1);
      checkVal("flush_no_grant", snap_ready, 4'b0000);
      if (c == 6) begin
        checkVal("flush_last_rsp", snap_rsp, 4'b0100);
        checkVal("flush_idle_early", snap_idle, 1'b0);
      end
      if (c >= 7) checkVal("flush_idle", snap_idle, 1'b1);
    end
    runCycle(1'b1, 4'hF, 1'b0);
    checkVal("unflush_hold", snap_ready, 4'b0000);
    runCycle(1'b1, 4'hF, 1'b0);
    checkVal("unflush_grant", snap_ready, 4'b1000);
    checkVal("unflush_idle", snap_idle, 1'b0);
    runCycle(1'b0, 4'h0, 1'b0);

    // Reset mid-stream with two items in flight
    runCycle(1'b1, 4'hF, 1'b0);
    runCycle(1'b1, 4'hF, 1'b0);
    runCycle(1'b0, 4'hF, 1'b0);
    checkVal("midrst_ready", snap_ready, 4'b0000);
    runCycle(1'b1, 4'hF, 1'b0);
    checkVal("midrst_first", snap_ready, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      runCycle(1'b1, 4'hF, 1'b0);
      checkVal("midrst_dropped", snap_rsp, 4'b0000);
    end
    runCycle(1'b1, 4'hF, 1'b0);
    checkVal("midrst_new_rsp", snap_rsp, 4'b0001);
    runCycle(1'b0, 4'h0, 1'b0);

    // Same-cycle grant and response on requester 1
    runCycle(1'b1, 4'b0010, 1'b0);
    checkVal("same_g0", snap_ready, 4'b0010);
    for (int i = 0; i < 3; i++) runCycle(1'b1, 4'b0000, 1'b0);
    runCycle(1'b1, 4'b0010, 1'b0);
    checkVal("same_ready", snap_ready, 4'b0010);
    checkVal("same_rsp", snap_rsp, 4'b0010);
    runCycle(1'b1, 4'b0010, 1'b0);
    checkVal("same_cnt_one", snap_ready, 4'b0010);
    runCycle(1'b1, 4'b0010, 1'b0);
    checkVal("same_cnt_full", snap_ready, 4'b0000);
`ifdef PIPE_SHARE_ARB_STATS_EN
    checkVal("same_stats", snap_gcnt1, 16'd3);
`endif

    // Randomized traffic with occasional flush episodes and resets
    rfl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) rfl = ~rfl;
      rrst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      rv   = 4'($urandom_range(0, 15));
      runCycle(rrst, rv, rfl);
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
